lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Sequential load/store unit between the MEM stage and a word-wide data-memory bus.
- Replaces the combinational, zero-latency memory access with a handshaked, multi-cycle transaction engine.
- Generates byte-lane write masks from the address offset, extracts and extends read data from the addressed lane, and flags misaligned or illegal accesses instead of issuing them.
- Parametrised in data width.

Parameters:
- XLEN, 64, data and bus width in bits (32 or 64); byte lanes NB = XLEN/8, offset bits OB = log2(NB).
- AW, 64, address width.
- MISALIGN_CHECK, 1, 1 = misaligned access returns error and skips the bus; 0 = address forced down to size alignment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents an access.
- req_ready  out  1  unit accepts the access (high only in IDLE).
- req_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size: 0=1B, 1=2B, 2=4B, 3=8B.
- req_addr  in  AW  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  MEM stage takes the result.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned address, or size 3 with XLEN=32.
- mem_valid  out  1  bus command valid.
- mem_ready  in  1  bus accepts command.
- mem_we  out  1  1 = write.
- mem_addr  out  AW  req_addr with low OB bits cleared.
- mem_wdata  out  XLEN  store data shifted to its lane.
- mem_wmask  out  NB  byte enables.
- mem_rsp_valid  in  1  bus completion; comes at least 1 cycle after command accept; also sent for writes.
- mem_rdata  in  XLEN  full bus word, valid with mem_rsp_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=0 while reset is asserted. mem_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0. Any in-flight transaction is dropped. A late mem_rsp_valid arriving after reset is ignored in IDLE.
- States: IDLE, CMD, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op, addr and wdata; let off = addr[OB-1:0].
  - Illegal access (off not a multiple of 2^size with MISALIGN_CHECK=1, or size 3 with XLEN=32) -> RESP with rsp_err=1 and rsp_rdata=0. No bus activity.
  - Otherwise -> CMD.
- CMD:
  - mem_valid=1 and command outputs registered stable.
  - mem_wmask = ((1<<2^size)-1) << off for stores; all ones for loads.
  - mem_wdata = req_wdata << (8*off).
  - Stay until mem_ready, then -> WAIT.
- WAIT:
  - mem_valid=0.
  - On mem_rsp_valid -> RESP.
  - Load: shift mem_rdata right by 8*off, then truncate to size. Sign-extend when op[2]=0, zero-extend when op[2]=1. Size 3 passes the full word.
  - Store: rsp_rdata=0.
- RESP:
  - rsp_valid=1, outputs held stable until rsp_ready, then -> IDLE.
  - req_ready is not asserted in the same cycle (no back-to-back bypass).
- Minimum latency, accept to rsp_valid: 3 cycles (CMD 1, WAIT 1, RESP).
- MISALIGN_CHECK=0: off is rounded down to a multiple of 2^size before lane selection; rsp_err only for size 3 with XLEN=32.
- req_op[2] is ignored for stores.
- Inputs other than clk/rst_n are sampled only at handshake edges.

Test Plan:
- XLEN=64. Load op=0x2 (LW), addr=0x8000_0004, mem_rdata=0x8765_4321_0000_0000, mem_ready=1, mem_rsp_valid 1 cycle later -> rsp_rdata=0xFFFF_FFFF_8765_4321, rsp_err=0, rsp_valid 3 cycles after accept.
- Store op=0x9 (SH), addr=0x1006, wdata=0x...ABCD -> mem_we=1, mem_wmask=0xC0, mem_wdata=0xABCD_0000_0000_0000, mem_addr=0x1000.
- Load op=0x6 (LWU), addr=0x1002 -> rsp_err=1, rsp_rdata=0, mem_valid never asserted, rsp_valid 1 cycle after accept.
- Backpressure: mem_ready low 4 cycles, then rsp_ready low 3 cycles -> mem_valid held with stable command, rsp_valid and rsp_rdata held stable, exactly one bus command issued.
- LBU op=0x4, addr=0x7, mem_rdata=0x80xx.. -> rsp_rdata=0x80. LB op=0x0, same data -> 0xFFFF_FFFF_FFFF_FF80.
- rst_n pulsed low while in WAIT -> all outputs 0 immediately. A later stray mem_rsp_valid produces no rsp_valid. The next request completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one MEM-stage access into a single handshaked
// bus transaction, with lane masking, load extension and alignment checks.
module lsu_mem_ctrl #(
    parameter int XLEN           = 64,
    parameter int AW             = 64,
    parameter int MISALIGN_CHECK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [OB-1:0]     off_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     wmask_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q;

    logic [1:0]        sz;
    logic [3:0]        szm;
    logic [OB-1:0]     lowm, off_raw, off_al;
    logic              misal, bad_size, illegal;
    logic [NB-1:0]     bm;

    assign sz = req_op[1:0];

    always_comb begin
        szm      = (4'd1 << sz) - 4'd1;
        lowm     = szm[OB-1:0];
        off_raw  = req_addr[OB-1:0];
        misal    = |(off_raw & lowm);
        bad_size = (XLEN == 32) && (sz == 2'd3);
        illegal  = bad_size || ((MISALIGN_CHECK != 0) && misal);
        // Without the check, the lane offset snaps down to size alignment
        off_al   = off_raw & ~lowm;
        unique case (sz)
            2'd0:    bm = NB'(8'h01);
            2'd1:    bm = NB'(8'h03);
            2'd2:    bm = NB'(8'h0F);
            default: bm = '1;
        endcase
    end

    logic [XLEN-1:0] sh, km, ext;
    logic            sbit;

    always_comb begin
        sh = mem_rdata >> {off_q, 3'b000};
        unique case (size_q)
            2'd0: begin
                km   = XLEN'(64'h0000_0000_0000_00FF);
                sbit = sh[7];
            end
            2'd1: begin
                km   = XLEN'(64'h0000_0000_0000_FFFF);
                sbit = sh[15];
            end
            2'd2: begin
                km   = XLEN'(64'h0000_0000_FFFF_FFFF);
                sbit = sh[31];
            end
            default: begin
                km   = '1;
                sbit = sh[XLEN-1];
            end
        endcase
        ext     = (sh & km) | ((sext_q & sbit) ? ~km : '0);
        rdata_d = we_q ? '0 : ext;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = illegal ? RESP : CMD;
            CMD:  if (mem_ready) state_d = WAIT;
            WAIT: if (mem_rsp_valid) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            sext_q  <= 1'b0;
            off_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                size_q  <= sz;
                sext_q  <= ~req_op[2];
                off_q   <= off_al;
                we_q    <= req_op[3];
                addr_q  <= {req_addr[AW-1:OB], {OB{1'b0}}};
                wdata_q <= req_wdata << {off_al, 3'b000};
                wmask_q <= req_op[3] ? (bm << off_al) : '1;
                err_q   <= illegal;
                rdata_q <= '0;
            end
            if (state_q == WAIT && mem_rsp_valid) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign req_ready = rst_n && (state_q == IDLE);
    assign mem_valid = (state_q == CMD);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised bench for lsu_mem_ctrl (XLEN=64) against a byte-arithmetic
// reference model, plus directed cases for backpressure and reset.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;

    int n_chk = 0;
    int n_err = 0;
    int ncmd  = 0;

    lsu_mem_ctrl #(.XLEN(64), .AW(64), .MISALIGN_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_valid && mem_ready) ncmd++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: byte count, offset arithmetic and two's-complement extension
    task automatic model(input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         output logic e_err, output logic [7:0] e_mask,
                         output logic [63:0] e_wdata,
                         output logic [63:0] e_addr,
                         output logic [63:0] e_rdata);
        int n, off, eoff;
        logic [63:0] v, lim;
        n       = 1 << op[1:0];
        off     = int'(addr % 64'd8);
        e_err   = (off % n) != 0;
        eoff    = off - (off % n);
        e_addr  = addr - 64'(off);
        e_wdata = wd << (8 * eoff);
        e_mask  = op[3] ? 8'(((1 << n) - 1) << eoff) : 8'hFF;
        v       = rd >> (8 * eoff);
        if (n < 8) begin
            lim = 64'd1 << (8 * n);
            v   = v % lim;
            if (!op[2] && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
                v = v | ~(lim - 64'd1);
        end
        e_rdata = (op[3] || e_err) ? 64'd0 : v;
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int dmr, input int drsp, input int drr);
        logic        e_err;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata, e_addr, e_rdata;
        int c0, cyc;
        model(op, addr, wd, rd, e_err, e_mask, e_wdata, e_addr, e_rdata);
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        c0        = ncmd;
        @(negedge clk);
        cyc       = 1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_addr  = rnd64();
        req_wdata = rnd64();
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (!e_err) begin
            for (int i = 0; i <= dmr; i++) begin
                chk("cmd_valid", 64'(mem_valid), 64'd1);
                chk("cmd_we", 64'(mem_we), 64'(op[3]));
                chk("cmd_addr", mem_addr, e_addr);
                chk("cmd_wmask", 64'(mem_wmask), 64'(e_mask));
                if (op[3]) chk("cmd_wdata", mem_wdata, e_wdata);
                chk("cmd_rsp_valid", 64'(rsp_valid), 64'd0);
                mem_ready = (i == dmr);
                @(negedge clk);
                cyc++;
            end
            mem_ready = 1'b0;
            for (int i = 0; i <= drsp; i++) begin
                chk("wait_mem_valid", 64'(mem_valid), 64'd0);
                chk("wait_rsp_valid", 64'(rsp_valid), 64'd0);
                mem_rsp_valid = (i == drsp);
                mem_rdata     = (i == drsp) ? rd : rnd64();
                @(negedge clk);
                cyc++;
            end
            mem_rsp_valid = 1'b0;
            mem_rdata     = rnd64();
        end
        chk("latency", 64'(cyc), e_err ? 64'd1 : 64'(dmr + drsp + 3));
        for (int i = 0; i <= drr; i++) begin
            chk("rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_err", 64'(rsp_err), 64'(e_err));
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_mem_valid", 64'(mem_valid), 64'd0);
            rsp_ready = (i == drr);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_done", 64'(rsp_valid), 64'd0);
        chk("req_ready_back", 64'(req_ready), 64'd1);
        chk("bus_cmds", 64'(ncmd - c0), e_err ? 64'd0 : 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] addr;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_op        = 4'd0;
        req_addr      = 64'd0;
        req_wdata     = 64'd0;
        rsp_ready     = 1'b0;
        mem_ready     = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 64'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // LW sign-extended from upper word
        run_txn(4'h2, 64'h8000_0004, rnd64(), 64'h8765_4321_0000_0000, 0, 0, 0);
        // SH into top lanes
        run_txn(4'h9, 64'h1006, 64'h1234_5678_9ABC_ABCD, rnd64(), 0, 0, 0);
        // LWU misaligned
        run_txn(4'h6, 64'h1002, rnd64(), rnd64(), 0, 0, 0);
        // Bus and response backpressure
        run_txn(4'h3, 64'h2000, rnd64(), 64'hDEAD_BEEF_CAFE_F00D, 4, 0, 3);
        // LBU / LB on the top byte
        run_txn(4'h4, 64'h7, rnd64(), 64'h8011_2233_4455_6677, 0, 1, 0);
        run_txn(4'h0, 64'h7, rnd64(), 64'h8011_2233_4455_6677, 0, 1, 0);

        // Reset while waiting for a store completion
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'hB;
        req_addr  = 64'h3008;
        req_wdata = 64'hFFFF_0000_1111_2222;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("pre_reset_we", 64'(mem_we), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rst_n         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rnd64();
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("stray_mem_valid", 64'(mem_valid), 64'd0);
        @(negedge clk);
        chk("stray_rsp_valid2", 64'(rsp_valid), 64'd0);
        run_txn(4'h1, 64'h4002, rnd64(), 64'h0000_0000_F00F_0000, 1, 1, 1);

        for (int t = 0; t < 60; t++) begin
            op   = 4'($urandom);
            addr = rnd64();
            if ($urandom_range(0, 2) != 0)
                addr = addr & ~((64'd1 << op[1:0]) - 64'd1);
            run_txn(op, addr, rnd64(), rnd64(),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
